window_gen_nxn: RTL and testbench
=================================

WINDOW_GEN_NXN -- requirements
Module: window_gen_nxn

Interface
REQ-001 SHALL have parameter PRA_WIDTH, default 8: pixel bit width.
REQ-002 SHALL have parameter WIN_SIZE, default 7: window edge N; legal odd values 3, 5, 7; R=(N-1)/2.
REQ-003 SHALL have parameter IMG_WIDTH, default 640: active pixels per line; legal 8..4096.
REQ-004 SHALL have port clk  input  1: sole clock; all logic rising-edge.
REQ-005 SHALL have port rst  input  1: reset, asynchronous and active-high.
REQ-006 SHALL have port i_image_vs  input  1: frame-valid level; a rising edge starts a frame.
REQ-007 SHALL have port i_image_hs  input  1: line-valid level, passed through delayed.
REQ-008 SHALL have port i_image_en  input  1: pixel strobe; i_data is accepted when high.
REQ-009 SHALL have port i_data  input  PRA_WIDTH: pixel, raster order.
REQ-010 SHALL have port o_image_vs  output  1: i_image_vs delayed 1 cycle.
REQ-011 SHALL have port o_image_hs  output  1: i_image_hs delayed 1 cycle.
REQ-012 SHALL have port o_image_en  output  1: window valid (all N*N taps are real pixels of the current frame).
REQ-013 SHALL have port o_window  output  N*N*PRA_WIDTH: tap (r,c) at bits [(r*N+c)*PRA_WIDTH +: PRA_WIDTH]; r=0 oldest line, c=0 oldest column.

Function
REQ-014 SHALL hold N-1 line buffers of IMG_WIDTH entries each, chained so buffer k delays by k lines; read-before-write at same address.
REQ-015 SHALL keep column counter col (0..IMG_WIDTH-1) and row counter row saturating at N-1.
REQ-016 SHALL, on each accepted pixel, write i_data to buffer 1 at col, cascade buffer k output into buffer k+1 at col, and shift every window row left by one, inserting the new column (bottom row = i_data, row r = buffer N-1-r output).
REQ-017 SHALL advance col by 1 per accepted pixel; at col=IMG_WIDTH-1, wrap col to 0 and increment row (saturating at N-1).
REQ-018 SHALL assert o_image_en 1 cycle after an accepted pixel iff row=N-1 and col>=N-1 at acceptance; otherwise deassert.
REQ-019 SHALL, when i_image_en is low, hold o_window and buffers unchanged and drive o_image_en=0 next cycle.
REQ-020 SHALL, on a rising edge of i_image_vs, clear col and row in that cycle; a pixel accepted in the same cycle is taken as col=0,row=0.
REQ-021 SHALL treat pixels beyond IMG_WIDTH in a line by wrapping per REQ-017 (no error flag); short lines are not padded.
REQ-022 SHALL have fixed latency 1 cycle from accepted pixel to o_window/o_image_en; window centre tap (R,R) equals pixel at (row_in-R, col_in-R).
REQ-023 SHALL make o_window taps from the previous line's tail don't-care whenever o_image_en=0; consumers gate on o_image_en.
REQ-024 SHALL produce exactly (H-N+1)*(IMG_WIDTH-N+1) o_image_en pulses for an H-line frame of full lines.

Reset
REQ-025 SHALL, while rst=1, force o_image_vs, o_image_hs, o_image_en, o_window, col, row and the vs edge detector to 0 immediately.
REQ-026 SHALL NOT require line-buffer contents to be cleared by reset; valid gating (REQ-018) masks stale data.
REQ-027 SHALL, after rst mid-frame, produce no o_image_en until a new i_image_vs rising edge plus N-1 full lines.

Verification
REQ-028 SHALL pass: N=3, IMG_WIDTH=8, 6 lines, pixel=row*16+col -> first o_image_en on pixel (2,2) with o_window tap(0,0)=0x00, tap(1,1)=0x11, tap(2,2)=0x22; 24 pulses total.
REQ-029 SHALL pass: N=7, IMG_WIDTH=16, 8 lines -> first valid at (6,6), centre tap=0x33; 20 pulses.
REQ-030 SHALL pass: random i_image_en gaps (50% duty) on REQ-028 stimulus -> identical o_window sequence on valid cycles.
REQ-031 SHALL pass: rst pulsed at line 3 of REQ-028, new frame started -> no o_image_en before new (2,2); counts match REQ-028.
REQ-032 SHALL pass: i_image_vs rise coincident with pixel strobe -> that pixel is (0,0) of new frame; no o_image_en leaks from prior frame.

Source files
------------

// File: rtl/window_gen_nxn_if.sv
// rtl/window_gen_nxn_if.sv - raster pixel stream in, N x N window stream out
interface window_gen_nxn_if #(
  parameter int PRA_WIDTH = 8,
  parameter int WIN_SIZE  = 7
);
  logic                                     i_image_vs;
  logic                                     i_image_hs;
  logic                                     i_image_en;
  logic [PRA_WIDTH-1:0]                     i_data;
  logic                                     o_image_vs;
  logic                                     o_image_hs;
  logic                                     o_image_en;
  logic [WIN_SIZE*WIN_SIZE*PRA_WIDTH-1:0]   o_window;

  modport master (
    output i_image_vs, i_image_hs, i_image_en, i_data,
    input  o_image_vs, o_image_hs, o_image_en, o_window
  );

  modport slave (
    input  i_image_vs, i_image_hs, i_image_en, i_data,
    output o_image_vs, o_image_hs, o_image_en, o_window
  );
endinterface

// File: rtl/window_gen_nxn.sv
// rtl/window_gen_nxn.sv - N x N sliding window generator over N-1 chained line buffers
module window_gen_nxn #(
  parameter int PRA_WIDTH = 8,
  parameter int WIN_SIZE  = 7,
  parameter int IMG_WIDTH = 640
) (
  input  logic            clk,
  input  logic            rst,
  window_gen_nxn_if.slave bus
);
  localparam int N  = WIN_SIZE;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(N);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] COL_VALID = CW'(N - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(N - 1);

  logic                 vs_d;
  logic                 vs_rise;
  logic [CW-1:0]        col, col_eff;
  logic [RW-1:0]        row, row_eff;
  logic [PRA_WIDTH-1:0] lbuf    [1:N-1][IMG_WIDTH];
  logic [PRA_WIDTH-1:0] lb_out  [1:N-1];
  logic [PRA_WIDTH-1:0] new_col [N];
  logic [PRA_WIDTH-1:0] win     [N][N];

  // A frame start overrides the counters in the same cycle it is seen.
  always_comb begin
    vs_rise = bus.i_image_vs & ~vs_d;
    col_eff = vs_rise ? '0 : col;
    row_eff = vs_rise ? '0 : row;
  end

  always_comb begin
    for (int k = 1; k < N; k++) lb_out[k] = lbuf[k][col_eff];
    new_col[N-1] = bus.i_data;
    for (int r = 0; r < N - 1; r++) new_col[r] = lb_out[N-1-r];
  end

  // Old contents are read above before this write lands at the same column.
  always_ff @(posedge clk) begin
    if (bus.i_image_en) begin
      lbuf[1][col_eff] <= bus.i_data;
      for (int k = 2; k < N; k++) lbuf[k][col_eff] <= lb_out[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_d           <= 1'b0;
      bus.o_image_vs <= 1'b0;
      bus.o_image_hs <= 1'b0;
      bus.o_image_en <= 1'b0;
      col            <= '0;
      row            <= '0;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) win[r][c] <= '0;
    end else begin
      vs_d           <= bus.i_image_vs;
      bus.o_image_vs <= bus.i_image_vs;
      bus.o_image_hs <= bus.i_image_hs;
      bus.o_image_en <= bus.i_image_en && (row_eff == ROW_LAST) && (col_eff >= COL_VALID);
      if (bus.i_image_en) begin
        for (int r = 0; r < N; r++) begin
          for (int c = 0; c < N - 1; c++) win[r][c] <= win[r][c+1];
          win[r][N-1] <= new_col[r];
        end
        if (col_eff == COL_LAST) begin
          col <= '0;
          row <= (row_eff == ROW_LAST) ? ROW_LAST : row_eff + 1'b1;
        end else begin
          col <= col_eff + 1'b1;
          row <= row_eff;
        end
      end else if (vs_rise) begin
        col <= '0;
        row <= '0;
      end
    end
  end

  always_comb begin
    bus.o_window = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        bus.o_window[(r*N+c)*PRA_WIDTH +: PRA_WIDTH] = win[r][c];
  end
endmodule

// File: tb/tb_window_gen_nxn.sv
// tb/tb_window_gen_nxn.sv - randomized self-checking bench against a frame-array window model
module tb_window_gen_nxn;
  localparam int WB = 7 * 7 * 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vs = 1'b0, hs = 1'b0, en = 1'b0;
  logic [7:0] data = 8'h00;

  window_gen_nxn_if #(.PRA_WIDTH(8), .WIN_SIZE(3)) ifa ();
  window_gen_nxn_if #(.PRA_WIDTH(8), .WIN_SIZE(7)) ifb ();

  assign ifa.i_image_vs = vs;
  assign ifa.i_image_hs = hs;
  assign ifa.i_image_en = en;
  assign ifa.i_data     = data;
  assign ifb.i_image_vs = vs;
  assign ifb.i_image_hs = hs;
  assign ifb.i_image_en = en;
  assign ifb.i_data     = data;

  window_gen_nxn #(.PRA_WIDTH(8), .WIN_SIZE(3), .IMG_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave)
  );
  window_gen_nxn #(.PRA_WIDTH(8), .WIN_SIZE(7), .IMG_WIDTH(16)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errs = 0;
  bit          sel = 1'b0;
  int          cur_n = 3, cur_w = 8;
  int          my = 0, mx = 0;
  bit          pvs = 1'b0;
  logic [7:0]  img [16][16];
  int          pulses = 0;
  bit          got_first = 1'b0;
  logic [WB-1:0] first_win;
  logic [WB-1:0] wlog [$];
  logic [WB-1:0] ref_log [$];

  task automatic chk(input string tag, input logic [WB-1:0] got, input logic [WB-1:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: a pixel at frame position (y,x) completes a window iff y,x >= N-1;
  // the window is the N x N block of the stored frame ending at (y,x).
  task automatic step(input bit v, input bit e, input logic [7:0] d);
    bit            valid;
    logic [WB-1:0] expw, gotw;
    logic          gvs, ghs, gen;
    vs = v; en = e; hs = e; data = d;
    if (v && !pvs) begin my = 0; mx = 0; end
    pvs = v;
    valid = 1'b0;
    expw = '0;
    if (e) begin
      if (my < 16) img[my][mx] = d;
      valid = (my >= cur_n - 1) && (mx >= cur_n - 1) && (my < 16);
      if (valid)
        for (int r = 0; r < cur_n; r++)
          for (int c = 0; c < cur_n; c++)
            expw[(r*cur_n+c)*8 +: 8] = img[my-cur_n+1+r][mx-cur_n+1+c];
      mx++;
      if (mx == cur_w) begin mx = 0; my++; end
    end
    @(posedge clk);
    #1;
    gvs  = sel ? ifb.o_image_vs : ifa.o_image_vs;
    ghs  = sel ? ifb.o_image_hs : ifa.o_image_hs;
    gen  = sel ? ifb.o_image_en : ifa.o_image_en;
    gotw = sel ? WB'(ifb.o_window) : WB'(ifa.o_window);
    chk("o_image_vs", WB'(gvs), WB'(v));
    chk("o_image_hs", WB'(ghs), WB'(e));
    chk("o_image_en", WB'(gen), WB'(valid));
    if (valid) begin
      chk("o_window", gotw, expw);
      wlog.push_back(gotw);
      if (!got_first) begin first_win = gotw; got_first = 1'b1; end
    end
    if (gen) pulses++;
  endtask

  task automatic frame(input int h, input bit gaps, input bit rnd, input bit coinc);
    pulses = 0; got_first = 1'b0; wlog.delete();
    if (!coinc) step(1'b1, 1'b0, 8'h00);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < cur_w; x++) begin
        for (int g = 0; g < 8 && gaps && ($urandom_range(0, 1) == 0); g++)
          step(1'b1, 1'b0, 8'($urandom));
        step(1'b1, 1'b1, rnd ? 8'($urandom) : 8'(y * 16 + x));
      end
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    chk("pulse_count", WB'(pulses), WB'((h - cur_n + 1) * (cur_w - cur_n + 1)));
  endtask

  task automatic chk_first3(input string tag);
    chk({tag, "_seen"}, WB'(got_first), WB'(1));
    chk({tag, "_tap00"}, WB'(first_win[7:0]), WB'(8'h00));
    chk({tag, "_tap11"}, WB'(first_win[32 +: 8]), WB'(8'h11));
    chk({tag, "_tap22"}, WB'(first_win[64 +: 8]), WB'(8'h22));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vs", WB'(ifa.o_image_vs), '0);
    chk("rst_en", WB'(ifa.o_image_en), '0);
    chk("rst_win", WB'(ifa.o_window), '0);
    chk("rst_win_b", WB'(ifb.o_window), '0);
    rst = 1'b0;
    step(1'b0, 1'b0, 8'h00);

    // N=3, W=8 pattern frame, then the same pixels with random strobe gaps
    frame(6, 1'b0, 1'b0, 1'b0);
    chk_first3("pat");
    ref_log = wlog;
    frame(6, 1'b1, 1'b0, 1'b0);
    chk("gap_len", WB'(wlog.size()), WB'(ref_log.size()));
    for (int i = 0; i < wlog.size() && i < ref_log.size(); i++)
      chk("gap_seq", wlog[i], ref_log[i]);
    frame(6, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset part-way through line 3
    pulses = 0;
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3 * 8 + 4; i++) step(1'b1, 1'b1, 8'($urandom));
    #2;
    vs = 1'b0; en = 1'b0; hs = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_en", WB'(ifa.o_image_en), '0);
    chk("arst_vs", WB'(ifa.o_image_vs), '0);
    chk("arst_win", WB'(ifa.o_window), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pvs = 1'b0; my = 0; mx = 0;
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    frame(6, 1'b0, 1'b0, 1'b0);
    chk_first3("post_rst");

    // Frame start coincident with a pixel strobe, mid-way through a valid region
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 2 * 8 + 5; i++) step(1'b1, 1'b1, 8'($urandom));
    step(1'b0, 1'b1, 8'($urandom));
    frame(6, 1'b0, 1'b0, 1'b1);
    chk_first3("coinc");

    // N=7, W=16
    sel = 1'b1; cur_n = 7; cur_w = 16;
    frame(8, 1'b0, 1'b0, 1'b0);
    chk("n7_seen", WB'(got_first), WB'(1));
    chk("n7_centre", WB'(first_win[(3*7+3)*8 +: 8]), WB'(8'h33));
    chk("n7_tap00", WB'(first_win[7:0]), WB'(8'h00));
    chk("n7_tap66", WB'(first_win[48*8 +: 8]), WB'(8'h66));
    frame(8, 1'b1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
